// File: rtl/lap_mem_arbiter.sv
// Single-port lap RAM arbiter: one-entry write buffer, two round-robin read ports
// (display, dump), all RAM controls driven from registers.
module lap_mem_arbiter #(
    parameter int DEPTH = 10,
    parameter int AW    = 4,
    parameter int DW    = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_req,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic             rd0_req,
    input  logic [AW-1:0]    rd0_addr,
    output logic             rd0_valid,
    output logic [DW-1:0]    rd0_data,
    input  logic             rd1_req,
    input  logic [AW-1:0]    rd1_addr,
    output logic             rd1_valid,
    output logic [DW-1:0]    rd1_data,
    output logic             mem_we,
    output logic             mem_re,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic [DEPTH-1:0] entry_valid,
    output logic             wr_overflow,
    output logic             addr_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_CAPT  = 2'd2
    } state_e;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_e             state_q;
    logic               buf_full_q;
    logic [AW-1:0]      buf_addr_q;
    logic [DW-1:0]      buf_data_q;
    logic               winner_q;
    logic               winner_err_q;
    logic               last_rd_q;
    logic               mem_we_q;
    logic               mem_re_q;
    logic [AW-1:0]      mem_addr_q;
    logic [DW-1:0]      mem_wdata_q;
    logic               rd0_valid_q;
    logic               rd1_valid_q;
    logic [DW-1:0]      rd0_data_q;
    logic [DW-1:0]      rd1_data_q;
    logic [DEPTH-1:0]   entry_valid_q;
    logic               wr_overflow_q;
    logic               addr_err_q;

    logic               decide;
    logic               rd0_elig;
    logic               rd1_elig;
    logic               grant1;
    logic [AW-1:0]      gnt_addr;
    logic               gnt_ok;
    logic               wr_in_range;
    logic               wr_ok;
    logic               do_write;
    logic               do_read;
    logic               wr_load;
    logic               wr_ovf;
    logic [DW-1:0]      capt_data;

    // Read ports: rdN_req is a level held with a stable address until the one-cycle
    // rdN_valid pulse; a requester is masked while its own read is completing so the
    // still-high request is not granted again before the requester can drop it.
    assign decide   = (state_q == IDLE) || (state_q == RD_CAPT);
    assign rd0_elig = rd0_req && !rd0_valid_q && !((state_q == RD_CAPT) && !winner_q);
    assign rd1_elig = rd1_req && !rd1_valid_q && !((state_q == RD_CAPT) && winner_q);
    assign grant1   = rd1_elig && (!rd0_elig || !last_rd_q);
    assign gnt_addr = grant1 ? rd1_addr : rd0_addr;
    assign gnt_ok   = ({1'b0, gnt_addr} < DEPTH_W);

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign wr_ok       = wr_req && wr_in_range && !clr;
    assign do_write    = decide && buf_full_q && !clr;
    assign do_read     = decide && !do_write && (rd0_elig || rd1_elig);
    assign wr_load     = wr_ok && (!buf_full_q || do_write);
    assign wr_ovf      = wr_ok && buf_full_q && !do_write;
    assign capt_data   = winner_err_q ? '0 : mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            buf_full_q    <= 1'b0;
            buf_addr_q    <= '0;
            buf_data_q    <= '0;
            winner_q      <= 1'b0;
            winner_err_q  <= 1'b0;
            last_rd_q     <= 1'b1;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd0_valid_q   <= 1'b0;
            rd1_valid_q   <= 1'b0;
            rd0_data_q    <= '0;
            rd1_data_q    <= '0;
            entry_valid_q <= '0;
            wr_overflow_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            mem_we_q    <= do_write;
            mem_re_q    <= do_read && gnt_ok;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
            addr_err_q  <= (wr_req && !wr_in_range) || (do_read && !gnt_ok);

            if (do_write) begin
                mem_addr_q  <= buf_addr_q;
                mem_wdata_q <= buf_data_q;
            end else if (do_read && gnt_ok) begin
                mem_addr_q  <= gnt_addr;
            end

            // Out-of-range reads still walk RD_ISSUE/RD_CAPT and answer with zero.
            if (state_q == RD_CAPT) begin
                if (winner_q) begin
                    rd1_valid_q <= 1'b1;
                    rd1_data_q  <= capt_data;
                end else begin
                    rd0_valid_q <= 1'b1;
                    rd0_data_q  <= capt_data;
                end
            end

            case (state_q)
                IDLE, RD_CAPT: begin
                    if (do_read) begin
                        state_q      <= RD_ISSUE;
                        winner_q     <= grant1;
                        winner_err_q <= !gnt_ok;
                        last_rd_q    <= grant1;
                    end else begin
                        state_q      <= IDLE;
                    end
                end
                RD_ISSUE: state_q <= RD_CAPT;
                default:  state_q <= IDLE;
            endcase

            if (clr) begin
                buf_full_q <= 1'b0;
            end else if (wr_load) begin
                buf_full_q <= 1'b1;
                buf_addr_q <= wr_addr;
                buf_data_q <= wr_data;
            end else if (do_write) begin
                buf_full_q <= 1'b0;
            end

            if (clr) begin
                entry_valid_q <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (do_write && (buf_addr_q == AW'(i))) begin
                        entry_valid_q[i] <= 1'b1;
                    end
                end
            end

            if (clr) begin
                wr_overflow_q <= 1'b0;
            end else if (wr_ovf) begin
                wr_overflow_q <= 1'b1;
            end
        end
    end

    assign rd0_valid   = rd0_valid_q;
    assign rd0_data    = rd0_data_q;
    assign rd1_valid   = rd1_valid_q;
    assign rd1_data    = rd1_data_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign entry_valid = entry_valid_q;
    assign wr_overflow = wr_overflow_q;
    assign addr_err    = addr_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_lap_mem_arbiter.sv
// Directed bench for lap_mem_arbiter with a behavioural single-port RAM model.
module tb_lap_mem_arbiter;

    localparam int DEPTH = 10;
    localparam int AW    = 4;
    localparam int DW    = 24;

    logic             clk;
    logic             reset;
    logic             clr;
    logic             wr_req;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             rd0_req;
    logic [AW-1:0]    rd0_addr;
    logic             rd0_valid;
    logic [DW-1:0]    rd0_data;
    logic             rd1_req;
    logic [AW-1:0]    rd1_addr;
    logic             rd1_valid;
    logic [DW-1:0]    rd1_data;
    logic             mem_we;
    logic             mem_re;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic [DEPTH-1:0] entry_valid;
    logic             wr_overflow;
    logic             addr_err;
    logic [1:0]       dbg_state;

    int n_checks;
    int n_fail;

    logic [DW-1:0] ram [0:15];

    lap_mem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_valid(rd0_valid), .rd0_data(rd0_data),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_valid(rd1_valid), .rd1_data(rd1_data),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .entry_valid(entry_valid), .wr_overflow(wr_overflow),
        .addr_err(addr_err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write on mem_we, read data registered the cycle after mem_re
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        mem_rdata = '0;
        reset = 1'b1; clr = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd0_req = 1'b0; rd0_addr = '0; rd1_req = 1'b0; rd1_addr = '0;

        // reset state
        tick(); tick();
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_re", 32'(mem_re), 32'h0);
        chk("rst_rd0_valid", 32'(rd0_valid), 32'h0);
        chk("rst_entry_valid", 32'(entry_valid), 32'h0);
        chk("rst_overflow", 32'(wr_overflow), 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);
        reset = 1'b0;
        tick();

        // single write addr 3
        wr_req = 1'b1; wr_addr = 4'd3; wr_data = 24'h012345;
        tick();
        wr_req = 1'b0;
        chk("w1_we_early", 32'(mem_we), 32'h0);
        tick();
        chk("w1_we", 32'(mem_we), 32'h1);
        chk("w1_addr", 32'(mem_addr), 32'h3);
        chk("w1_data", 32'(mem_wdata), 32'h012345);
        chk("w1_entry", 32'(entry_valid), 32'h008);
        tick();
        chk("w1_we_off", 32'(mem_we), 32'h0);

        // rd0 alone at addr 3
        rd0_req = 1'b1; rd0_addr = 4'd3;
        tick();
        chk("r0_re", 32'(mem_re), 32'h1);
        chk("r0_addr", 32'(mem_addr), 32'h3);
        chk("r0_state", 32'(dbg_state), 32'h1);
        tick();
        chk("r0_re_off", 32'(mem_re), 32'h0);
        chk("r0_valid_early", 32'(rd0_valid), 32'h0);
        tick();
        chk("r0_valid", 32'(rd0_valid), 32'h1);
        chk("r0_data", 32'(rd0_data), 32'h012345);
        chk("r0_rd1_quiet", 32'(rd1_valid), 32'h0);
        rd0_req = 1'b0;
        tick();
        chk("r0_valid_off", 32'(rd0_valid), 32'h0);
        chk("r0_idle", 32'(dbg_state), 32'h0);

        // back-to-back writes to 1 and 2
        wr_req = 1'b1; wr_addr = 4'd1; wr_data = 24'h111111;
        tick();
        wr_addr = 4'd2; wr_data = 24'h222222;
        tick();
        wr_req = 1'b0;
        tick();
        tick();
        chk("w12_entry", 32'(entry_valid), 32'h00E);
        chk("w12_overflow", 32'(wr_overflow), 32'h0);

        // both readers held: last grant was rd0, so rd1 first, then alternate
        rd0_req = 1'b1; rd0_addr = 4'd1; rd1_req = 1'b1; rd1_addr = 4'd2;
        tick();
        chk("rr_first_addr", 32'(mem_addr), 32'h2);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i % 4 == 2) begin
                chk("rr_rd1_valid", 32'(rd1_valid), 32'h1);
                chk("rr_rd1_data", 32'(rd1_data), 32'h222222);
                chk("rr_rd0_quiet", 32'(rd0_valid), 32'h0);
            end else if (i % 4 == 0) begin
                chk("rr_rd0_valid", 32'(rd0_valid), 32'h1);
                chk("rr_rd0_data", 32'(rd0_data), 32'h111111);
                chk("rr_rd1_quiet", 32'(rd1_valid), 32'h0);
            end else begin
                chk("rr_gap", 32'({rd0_valid, rd1_valid}), 32'h0);
            end
            if (i == 7) begin
                rd0_req = 1'b0; rd1_req = 1'b0;
            end
        end
        tick();
        chk("rr_idle", 32'(dbg_state), 32'h0);

        // rd1 read with writes landing at grant edge and during RD_ISSUE
        rd1_req = 1'b1; rd1_addr = 4'd2;
        wr_req = 1'b1; wr_addr = 4'd5; wr_data = 24'h005555;
        tick();
        chk("ov_re", 32'(mem_re), 32'h1);
        chk("ov_re_addr", 32'(mem_addr), 32'h2);
        chk("ov_flag_clear", 32'(wr_overflow), 32'h0);
        wr_addr = 4'd6; wr_data = 24'h006666;
        tick();
        wr_req = 1'b0;
        chk("ov_flag_set", 32'(wr_overflow), 32'h1);
        chk("ov_no_we", 32'(mem_we), 32'h0);
        tick();
        chk("ov_we", 32'(mem_we), 32'h1);
        chk("ov_we_addr", 32'(mem_addr), 32'h5);
        chk("ov_we_data", 32'(mem_wdata), 32'h005555);
        chk("ov_rd1_valid", 32'(rd1_valid), 32'h1);
        chk("ov_rd1_data", 32'(rd1_data), 32'h222222);
        rd1_req = 1'b0;
        tick();
        chk("ov_we_off", 32'(mem_we), 32'h0);
        chk("ov_entry", 32'(entry_valid), 32'h02E);
        chk("ov_sticky", 32'(wr_overflow), 32'h1);
        chk("ov_rd0_hold", 32'(rd0_data), 32'h111111);

        // out-of-range write then out-of-range read
        wr_req = 1'b1; wr_addr = 4'd12; wr_data = 24'hABCDEF;
        tick();
        wr_req = 1'b0;
        chk("ae_wr_pulse", 32'(addr_err), 32'h1);
        tick();
        chk("ae_wr_gap", 32'(addr_err), 32'h0);
        chk("ae_wr_no_we", 32'(mem_we), 32'h0);
        rd0_req = 1'b1; rd0_addr = 4'd15;
        tick();
        chk("ae_rd_pulse", 32'(addr_err), 32'h1);
        chk("ae_rd_no_re", 32'(mem_re), 32'h0);
        tick();
        chk("ae_rd_gap", 32'(addr_err), 32'h0);
        tick();
        chk("ae_rd_valid", 32'(rd0_valid), 32'h1);
        chk("ae_rd_data", 32'(rd0_data), 32'h0);
        rd0_req = 1'b0;
        tick();
        chk("ae_entry", 32'(entry_valid), 32'h02E);
        chk("ae_no_we", 32'(mem_we), 32'h0);

        // clr with a simultaneous write: write dropped, no overflow
        clr = 1'b1; wr_req = 1'b1; wr_addr = 4'd4; wr_data = 24'h004444;
        tick();
        clr = 1'b0; wr_req = 1'b0;
        chk("clr_overflow", 32'(wr_overflow), 32'h0);
        chk("clr_entry", 32'(entry_valid), 32'h0);
        tick();
        chk("clr_no_we", 32'(mem_we), 32'h0);

        // fill 0..9 one per cycle, then clr
        for (int i = 0; i < DEPTH; i++) begin
            wr_req = 1'b1; wr_addr = AW'(i); wr_data = DW'(i * 'h111);
            tick();
        end
        wr_req = 1'b0;
        tick();
        chk("fill_entry", 32'(entry_valid), 32'h3FF);
        chk("fill_last_data", 32'(mem_wdata), 32'h000999);
        chk("fill_overflow", 32'(wr_overflow), 32'h0);
        rd1_req = 1'b1; rd1_addr = 4'd7;
        tick(); tick(); tick();
        chk("fill_rd1_valid", 32'(rd1_valid), 32'h1);
        chk("fill_rd1_data", 32'(rd1_data), 32'h000777);
        rd1_req = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("fill_clr_entry", 32'(entry_valid), 32'h0);

        // reset during RD_ISSUE
        wr_req = 1'b1; wr_addr = 4'd8; wr_data = 24'h008888;
        tick();
        wr_req = 1'b0;
        tick();
        chk("mr_entry", 32'(entry_valid), 32'h100);
        rd0_req = 1'b1; rd0_addr = 4'd8;
        tick();
        chk("mr_re", 32'(mem_re), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_re_zero", 32'(mem_re), 32'h0);
        chk("mr_addr_zero", 32'(mem_addr), 32'h0);
        chk("mr_entry_zero", 32'(entry_valid), 32'h0);
        chk("mr_state_zero", 32'(dbg_state), 32'h0);
        rd0_req = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mr_no_valid", 32'({rd0_valid, rd1_valid}), 32'h0);
        end
        chk("mr_idle", 32'(dbg_state), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lap_mem_arbiter.md
Name: lap_mem_arbiter

Overview:
Arbitrates one single-port synchronous lap-time RAM between three requesters:
- the capture path, which writes a lap result on each stopwatch result strobe;
- the display path, which reads the entry currently selected for viewing;
- the dump path, which reads entries out for serial export.

The block sits between the stopwatch control FSM / display scanner and the RAM macro, and owns every RAM control signal.

Parameters:
DEPTH, 10, number of lap entries (valid addresses 0..DEPTH-1)
AW, 4, address width, must satisfy 2**AW >= DEPTH
DW, 24, lap value width (BCD mm:ss:cc)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear of entry bitmap, write buffer and overflow flag
wr_req  in  1  one-cycle write strobe
wr_addr  in  AW  write address
wr_data  in  DW  write data
rd0_req  in  1  display read request, level, held until rd0_valid
rd0_addr  in  AW  display read address, stable while rd0_req high
rd0_valid  out  1  one-cycle pulse: rd0_data valid
rd0_data  out  DW  display read data
rd1_req  in  1  dump read request, level
rd1_addr  in  AW  dump read address
rd1_valid  out  1  one-cycle pulse: rd1_data valid
rd1_data  out  DW  dump read data
mem_we  out  1  RAM write enable (registered)
mem_re  out  1  RAM read enable (registered)
mem_addr  out  AW  RAM address (registered)
mem_wdata  out  DW  RAM write data (registered)
mem_rdata  in  DW  RAM read data, valid in the cycle after mem_re
entry_valid  out  DEPTH  bit i set once address i has been written
wr_overflow  out  1  sticky: a write was dropped
addr_err  out  1  one-cycle pulse: out-of-range address rejected

Behaviour:
- Reset (asynchronous): all outputs 0, write buffer empty, FSM in IDLE, last_rd = 1 (rd0 wins the first tie).
- Write buffer (1 entry):
  - wr_req with wr_addr < DEPTH loads the buffer.
  - wr_req with wr_addr >= DEPTH is dropped and pulses addr_err for one cycle.
  - wr_req while the buffer is full and not draining that cycle drops the new write and sets wr_overflow.
- FSM states: IDLE, RD_ISSUE, RD_CAPT. Decision is made at each edge in IDLE or RD_CAPT.
  - Buffer full: issue a write, with mem_we=1, mem_addr/mem_wdata from the buffer, for one cycle. The buffer empties and entry_valid[addr] is set at the same edge. The state returns to IDLE.
  - Else, a read request pending with in-range address: issue the read, with mem_re=1, mem_addr = winner address. Go to RD_ISSUE and record the winner.
  - Read with address >= DEPTH: pulse addr_err and return a response with data 0 via the normal RD_CAPT path, without using the RAM.
  - RD_ISSUE → RD_CAPT unconditionally. In RD_CAPT, winner data = mem_rdata and the winner's valid pulses for one cycle.
  - RD_CAPT may issue the next command in the same cycle (back-to-back).
- Read latency: request sampled at edge k → mem_re high during cycle k..k+1 → rdN_valid high during cycle k+2..k+3.
  - Minimum 3 cycles between reads from the same requester, because the requester drops or changes req after valid.
  - A request still high on the valid cycle is not re-granted at that edge.
- Round-robin: when both read requests are pending, grant the requester not equal to last_rd. last_rd updates on every read grant. A single pending requester always wins.
- Writes have priority over reads only at a decision point; an issued read is never aborted.
  - Continuous wr_req at one per cycle starves reads (accepted).
  - At most one write can be pending while a read is in flight, so a second wr_req during RD_ISSUE overflows.
- clr:
  - clears entry_valid, the write buffer and wr_overflow.
  - An in-flight read completes normally.
  - A wr_req in the same cycle as clr is dropped without setting overflow.
- rdN_data holds its last value between valid pulses. mem_we and mem_re are never high together.

Test Plan:
- Single wr_req addr 3 data 0x012345 from idle → mem_we high exactly 1 cycle with addr 3 / data 0x012345; entry_valid = 10'b0000001000.
- rd0_req addr 3 alone; RAM model returns 0x012345 → mem_re at k, rd0_valid pulse at k+2 with rd0_data = 0x012345; rd1_valid stays 0.
- rd0 and rd1 held continuously with addrs 1 and 2 → grants alternate rd0, rd1, rd0, …, one response every 2 cycles; no requester served twice in a row.
- rd1 granted, wr_req at RD_ISSUE cycle, second wr_req next cycle → first write issued at the RD_CAPT decision, second dropped, wr_overflow = 1 until clr.
- wr_req addr 12 and rd0_req addr 15 → two addr_err pulses, no mem_we, rd0_valid with data 0, entry_valid unchanged.
- Reset asserted mid-read (during RD_ISSUE) → all outputs 0 immediately, no rd valid pulse after release; clr after writes to 0..9 → entry_valid = 0.
